// File: rtl/step_clock_gen.sv
// ---------------------------------------------------------------------------
// step_clock_gen
//
// Produces the CPU clock for the DE0 LEGv8 board top level from CLOCK_50.
//   * Step mode (run_mode = 0): every debounced press of the active-low step
//     button yields exactly one cpu_clock pulse.
//   * Run mode  (run_mode = 1): a programmable divider yields a free-running
//     cpu_clock.
// A wrapping 16-bit count of cpu_clock rising edges feeds the debug displays.
//
// Each pulse is PULSE_LEN cycles high followed by at least PULSE_LEN cycles
// low. The low time includes the IDLE cycle in which the next event is
// sampled. This lets the fastest run period (2*PULSE_LEN) produce an exact
// high/low square wave.
//
// Ports
//   clock        in   board clock (CLOCK_50)
//   reset        in   synchronous, active-high reset
//   step_btn_n   in   raw step button, active low, asynchronous to clock
//   run_mode     in   1 = run (divided clock), 0 = single step
//   run_speed    in   run period = RUN_DIV >> (2*run_speed), floor 2*PULSE_LEN
//   cpu_clock    out  registered CPU clock
//   tick_pulse   out  one-cycle strobe on the cycle cpu_clock rises
//   tick_count   out  count of cpu_clock rising edges, wraps at 16 bits
//   btn_level    out  debounced button state, 1 = pressed
// ---------------------------------------------------------------------------
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20,
  parameter int PULSE_LEN       = 4,
  parameter int RUN_DIV         = 25000000,
  parameter int DIV_W           = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step_btn_n,
  input  logic        run_mode,
  input  logic [1:0]  run_speed,
  output logic        cpu_clock,
  output logic        tick_pulse,
  output logic [15:0] tick_count,
  output logic        btn_level
);

  localparam int PL_W    = $clog2(PULSE_LEN + 1);
  localparam int GAP_LEN = PULSE_LEN - 1;  // The IDLE cycle supplies the last low cycle.

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_BASE  = DIV_W'(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(2 * PULSE_LEN);
  localparam logic [PL_W-1:0]  HIGH_LAST = PL_W'(PULSE_LEN - 1);
  localparam logic [PL_W-1:0]  GAP_LAST  = PL_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Button synchroniser
  // ---------------------------------------------------------------------
  logic sync_ff1, sync_ff2;
  logic btn_synced;

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge. Blocking assignments here would
  // let sync_ff2 see the new sync_ff1 and collapse the two stages into one.
  always_ff @(posedge clock) begin
    if (reset) begin
      // Reset to "released" so that the bench or board sees no phantom press.
      sync_ff1 <= 1'b1;
      sync_ff2 <= 1'b1;
    end else begin
      sync_ff1 <= step_btn_n;
      sync_ff2 <= sync_ff1;
    end
  end

  assign btn_synced = ~sync_ff2;

  // ---------------------------------------------------------------------
  // Debounce: btn_level follows btn_synced only after DEBOUNCE_CYCLES of
  // continuous disagreement. Any agreement restarts the count.
  // ---------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt;
  logic            db_accept;
  logic            press_evt;

  assign db_accept = (btn_synced != btn_level) && (db_cnt == DB_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (btn_synced == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_level <= ~btn_level;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // A press is the accept cycle of a 0->1 change. Releases never count.
  assign press_evt = ~run_mode & db_accept & ~btn_level;

  // ---------------------------------------------------------------------
  // Run-mode divider
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_shifted;
  logic [DIV_W-1:0] div_period;
  logic [DIV_W-1:0] div_last;
  logic             run_tick;

  assign div_shifted = DIV_BASE >> {run_speed, 1'b0};
  assign div_period  = (div_shifted < DIV_FLOOR) ? DIV_FLOOR : div_shifted;
  assign div_last    = div_period - DIV_W'(1);
  // ">=" makes a count left stranded above a newly shortened period wrap
  // immediately instead of running the counter all the way around.
  assign run_tick    = run_mode & (div_cnt >= div_last);

  always_ff @(posedge clock) begin
    if (reset || !run_mode) begin
      div_cnt <= '0;
    end else if (run_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Pulse FSM
  // ---------------------------------------------------------------------
  state_t          state, state_nxt;
  logic [PL_W-1:0] pulse_cnt, pulse_cnt_nxt;
  logic            cpu_clock_nxt;
  logic            tick_pulse_nxt;
  logic [15:0]     tick_count_nxt;
  logic            clk_evt;

  // The two event sources are mutually exclusive because both are gated by
  // run_mode.
  assign clk_evt = press_evt | run_tick;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pulse_cnt  <= '0;
      cpu_clock  <= 1'b0;
      tick_pulse <= 1'b0;
      tick_count <= '0;
    end else begin
      state      <= state_nxt;
      pulse_cnt  <= pulse_cnt_nxt;
      cpu_clock  <= cpu_clock_nxt;
      tick_pulse <= tick_pulse_nxt;
      tick_count <= tick_count_nxt;
    end
  end

  // NOTE: every signal written here gets a default value first. A path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt      = state;
    pulse_cnt_nxt  = pulse_cnt;
    cpu_clock_nxt  = 1'b0;
    tick_pulse_nxt = 1'b0;
    tick_count_nxt = tick_count;

    case (state)
      IDLE: begin
        if (clk_evt) begin
          state_nxt      = HIGH;
          pulse_cnt_nxt  = '0;
          cpu_clock_nxt  = 1'b1;
          tick_pulse_nxt = 1'b1;
          tick_count_nxt = tick_count + 16'd1;
        end
      end

      HIGH: begin
        // Events arriving here are dropped and not queued.
        if (pulse_cnt == HIGH_LAST) begin
          pulse_cnt_nxt = '0;
          state_nxt     = (GAP_LEN == 0) ? IDLE : GAP;
        end else begin
          pulse_cnt_nxt = pulse_cnt + PL_W'(1);
          cpu_clock_nxt = 1'b1;
        end
      end

      GAP: begin
        if (pulse_cnt == GAP_LAST) begin
          pulse_cnt_nxt = '0;
          state_nxt     = IDLE;
        end else begin
          pulse_cnt_nxt = pulse_cnt + PL_W'(1);
        end
      end

      default: begin
        state_nxt     = IDLE;
        pulse_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_step_clock_gen.sv
// ---------------------------------------------------------------------------
// tb_step_clock_gen
//
// Directed test of step_clock_gen with small parameters
// (DEBOUNCE_CYCLES=8, PULSE_LEN=2, RUN_DIV=64).
// Covers reset, step-mode press, glitch rejection, run-mode periods,
// speed change, tick_count wrap, and reset in the middle of a pulse.
// ---------------------------------------------------------------------------
module tb_step_clock_gen;

  localparam int DEBOUNCE_CYCLES = 8;
  localparam int DB_W            = 4;
  localparam int PULSE_LEN       = 2;
  localparam int RUN_DIV         = 64;
  localparam int DIV_W           = 7;

  logic        clock      = 1'b0;
  logic        reset      = 1'b1;
  logic        step_btn_n = 1'b1;
  logic        run_mode   = 1'b0;
  logic [1:0]  run_speed  = 2'd0;
  logic        cpu_clock;
  logic        tick_pulse;
  logic [15:0] tick_count;
  logic        btn_level;

  int n_assert = 0;
  int n_fail   = 0;

  step_clock_gen #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W),
    .PULSE_LEN      (PULSE_LEN),
    .RUN_DIV        (RUN_DIV),
    .DIV_W          (DIV_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .step_btn_n(step_btn_n),
    .run_mode  (run_mode),
    .run_speed (run_speed),
    .cpu_clock (cpu_clock),
    .tick_pulse(tick_pulse),
    .tick_count(tick_count),
    .btn_level (btn_level)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int          pulses;
    int          highs;
    int          first;
    int          last;
    int          bad_gap;
    int          lvl_seen;
    logic [31:0] cpu_tr;
    logic        found;

    // ---- 1. reset and idle ------------------------------------------------
    repeat (3) step();
    check("rst_cpu_clock",  cpu_clock,  0);
    check("rst_tick_pulse", tick_pulse, 0);
    check("rst_tick_count", tick_count, 0);
    check("rst_btn_level",  btn_level,  0);
    reset  = 1'b0;
    pulses = 0;
    highs  = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      pulses += int'(tick_pulse);
      highs  += int'(cpu_clock);
    end
    check("idle_pulses",     pulses,     0);
    check("idle_cpu_high",   highs,      0);
    check("idle_tick_count", tick_count, 0);

    // ---- 2. single press in step mode -------------------------------------
    step_btn_n = 1'b0;
    first  = -1;
    cpu_tr = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      cpu_tr[k] = cpu_clock;
      if (first < 0 && btn_level) first = k;
      if (k == 10) check("press_tick_pulse_rise", tick_pulse, 1);
      if (k == 11) check("press_tick_pulse_once", tick_pulse, 0);
    end
    check("press_btn_latency", first,      10);
    check("press_cpu_trace",   cpu_tr,     32'h0000_0C00);
    check("press_tick_count",  tick_count, 1);
    step_btn_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      pulses += int'(tick_pulse);
    end
    check("release_btn_level",  btn_level,  0);
    check("release_no_pulse",   pulses,     0);
    check("release_tick_count", tick_count, 1);

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst2_tick_count", tick_count, 0);

    // ---- 3. bouncing button shorter than the debounce window ---------------
    lvl_seen = 0;
    pulses   = 0;
    for (int r = 0; r < 4; r++) begin
      step_btn_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
        step();
        lvl_seen += int'(btn_level);
        pulses   += int'(tick_pulse);
      end
      step_btn_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        lvl_seen += int'(btn_level);
        pulses   += int'(tick_pulse);
      end
    end
    for (int k = 0; k < 12; k++) begin
      step();
      lvl_seen += int'(btn_level);
      pulses   += int'(tick_pulse);
    end
    check("glitch_btn_level",  lvl_seen,   0);
    check("glitch_pulses",     pulses,     0);
    check("glitch_tick_count", tick_count, 0);

    // ---- 4. run mode, speed 0 then speed 2 ---------------------------------
    run_speed = 2'd0;
    run_mode  = 1'b1;
    pulses = 0; first = -1; last = -1; bad_gap = 0;
    for (int k = 1; k <= 640; k++) begin
      step();
      if (tick_pulse) begin
        if (last >= 0 && (k - last) != 64) bad_gap++;
        if (first < 0) first = k;
        last = k;
        pulses++;
      end
    end
    check("run0_pulses",     pulses,     10);
    check("run0_first",      first,      64);
    check("run0_spacing",    bad_gap,    0);
    check("run0_tick_count", tick_count, 10);

    run_speed = 2'd2;
    pulses = 0; first = -1; last = -1; bad_gap = 0;
    cpu_tr = '0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k <= 8) cpu_tr[k] = cpu_clock;
      if (tick_pulse) begin
        if (last >= 0 && (k - last) != 4) bad_gap++;
        if (first < 0) first = k;
        last = k;
        pulses++;
      end
    end
    check("run2_pulses",     pulses,     10);
    check("run2_first",      first,      4);
    check("run2_spacing",    bad_gap,    0);
    check("run2_cpu_trace",  cpu_tr,     32'h0000_0132);
    check("run2_tick_count", tick_count, 20);

    // Leave run mode mid-pulse: the current pulse completes, then nothing.
    run_mode = 1'b0;
    pulses   = 0;
    step();
    check("mode_off_pulse_completes", cpu_clock, 1);
    for (int k = 0; k < 20; k++) begin
      step();
      pulses += int'(tick_pulse);
    end
    check("mode_off_no_pulse",   pulses,     0);
    check("mode_off_tick_count", tick_count, 20);

    // A count stranded above a shortened period wraps at once.
    run_speed = 2'd0;
    run_mode  = 1'b1;
    for (int k = 0; k < 30; k++) step();
    check("speed_pre_no_pulse", tick_count, 20);
    run_speed = 2'd2;
    step();
    check("speed_wrap_at_once", tick_pulse, 1);
    run_mode = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("speed_tick_count", tick_count, 21);

    // ---- 5. tick_count wrap ------------------------------------------------
    force dut.tick_count = 16'hFFFF;
    step();
    step();
    release dut.tick_count;
    step();
    check("wrap_preload", tick_count, 16'hFFFF);
    run_speed = 2'd2;
    run_mode  = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    check("wrap_tick_pulse", tick_pulse, 1);
    check("wrap_to_zero",    tick_count, 0);
    run_mode = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("wrap_hold", tick_count, 0);

    // ---- 6. reset while cpu_clock is high ----------------------------------
    run_speed = 2'd2;
    run_mode  = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (tick_pulse) found = 1'b1;
    end
    check("midrst_found_pulse", found,     1);
    check("midrst_cpu_high",    cpu_clock, 1);
    reset      = 1'b1;
    run_mode   = 1'b0;
    step_btn_n = 1'b0;
    step();
    check("midrst_cpu_drop",   cpu_clock,  0);
    check("midrst_tick_count", tick_count, 0);
    step();
    step();
    reset = 1'b0;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first < 0 && btn_level) first = k;
    end
    check("midrst_press_latency", first,      10);
    check("midrst_press_count",   tick_count, 1);
    step_btn_n = 1'b1;
    for (int k = 0; k < 20; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
